// File: rtl/sonic_sight_pkg.sv
// Shared definitions for the beam sweep scheduler and its sine LUT.
//   sweep_state_t : states of the beam sweep sequencer
//   ANGLE_WIDTH   : width of a signed steering angle in degrees
//   SIN_WIDTH     : width of the unsigned sine magnitude
//   SIN_ONE       : magnitude code for sin = 1.0
package sonic_sight_pkg;

  localparam int ANGLE_WIDTH = 8;
  localparam int SIN_WIDTH   = 17;
  localparam logic [SIN_WIDTH-1:0] SIN_ONE = 17'd65536;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EMIT,
    ST_FIRE,
    ST_WAIT,
    ST_ADVANCE
  } sweep_state_t;

endpackage

// File: rtl/sin_lut.sv
// Combinational sine-magnitude lookup over whole degrees.
//   angle : signed steering angle in degrees
//   mag   : |sin(angle)| scaled so that SIN_ONE = 1.0, rounded to nearest
//   neg   : 1 when the angle is negative
// Magnitudes of 90 degrees and beyond return SIN_ONE.
module sin_lut
  import sonic_sight_pkg::*;
(
  input  logic signed [ANGLE_WIDTH-1:0] angle,
  output logic        [SIN_WIDTH-1:0]   mag,
  output logic                          neg
);

  logic [ANGLE_WIDTH-1:0] abs_angle;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned, which would infer a latch.
    neg       = angle[ANGLE_WIDTH-1];
    abs_angle = neg ? ANGLE_WIDTH'(-angle) : angle;
    mag       = SIN_ONE;
    case (abs_angle)
      8'd0:  mag = 17'd0;     8'd1:  mag = 17'd1144;  8'd2:  mag = 17'd2287;  8'd3:  mag = 17'd3430;  8'd4:  mag = 17'd4572;
      8'd5:  mag = 17'd5712;  8'd6:  mag = 17'd6850;  8'd7:  mag = 17'd7987;  8'd8:  mag = 17'd9121;  8'd9:  mag = 17'd10252;
      8'd10: mag = 17'd11380; 8'd11: mag = 17'd12505; 8'd12: mag = 17'd13626; 8'd13: mag = 17'd14742; 8'd14: mag = 17'd15855;
      8'd15: mag = 17'd16962; 8'd16: mag = 17'd18064; 8'd17: mag = 17'd19161; 8'd18: mag = 17'd20252; 8'd19: mag = 17'd21336;
      8'd20: mag = 17'd22415; 8'd21: mag = 17'd23486; 8'd22: mag = 17'd24550; 8'd23: mag = 17'd25607; 8'd24: mag = 17'd26656;
      8'd25: mag = 17'd27697; 8'd26: mag = 17'd28729; 8'd27: mag = 17'd29753; 8'd28: mag = 17'd30767; 8'd29: mag = 17'd31772;
      8'd30: mag = 17'd32768; 8'd31: mag = 17'd33754; 8'd32: mag = 17'd34729; 8'd33: mag = 17'd35693; 8'd34: mag = 17'd36647;
      8'd35: mag = 17'd37590; 8'd36: mag = 17'd38521; 8'd37: mag = 17'd39441; 8'd38: mag = 17'd40348; 8'd39: mag = 17'd41243;
      8'd40: mag = 17'd42126; 8'd41: mag = 17'd42995; 8'd42: mag = 17'd43852; 8'd43: mag = 17'd44695; 8'd44: mag = 17'd45525;
      8'd45: mag = 17'd46341; 8'd46: mag = 17'd47143; 8'd47: mag = 17'd47930; 8'd48: mag = 17'd48703; 8'd49: mag = 17'd49461;
      8'd50: mag = 17'd50204; 8'd51: mag = 17'd50931; 8'd52: mag = 17'd51643; 8'd53: mag = 17'd52339; 8'd54: mag = 17'd53020;
      8'd55: mag = 17'd53684; 8'd56: mag = 17'd54332; 8'd57: mag = 17'd54963; 8'd58: mag = 17'd55578; 8'd59: mag = 17'd56175;
      8'd60: mag = 17'd56756; 8'd61: mag = 17'd57319; 8'd62: mag = 17'd57865; 8'd63: mag = 17'd58393; 8'd64: mag = 17'd58903;
      8'd65: mag = 17'd59396; 8'd66: mag = 17'd59870; 8'd67: mag = 17'd60326; 8'd68: mag = 17'd60764; 8'd69: mag = 17'd61183;
      8'd70: mag = 17'd61584; 8'd71: mag = 17'd61966; 8'd72: mag = 17'd62328; 8'd73: mag = 17'd62672; 8'd74: mag = 17'd62997;
      8'd75: mag = 17'd63303; 8'd76: mag = 17'd63589; 8'd77: mag = 17'd63856; 8'd78: mag = 17'd64104; 8'd79: mag = 17'd64332;
      8'd80: mag = 17'd64540; 8'd81: mag = 17'd64729; 8'd82: mag = 17'd64898; 8'd83: mag = 17'd65048; 8'd84: mag = 17'd65177;
      8'd85: mag = 17'd65287; 8'd86: mag = 17'd65376; 8'd87: mag = 17'd65446; 8'd88: mag = 17'd65496; 8'd89: mag = 17'd65526;
      default: mag = SIN_ONE;
    endcase
  end

endmodule

// File: rtl/beam_sweep_scheduler.sv
// Transmit beam sweep sequencer for the ultrasonic array. Steps the steering
// angle from ANGLE_MIN to ANGLE_MAX, looks up sin(angle), emits one transmit
// delay per element, fires a burst and waits for the receive path.
//   clk_in          : clock
//   rst_in          : synchronous active-high reset
//   start_in        : begin a sweep (honoured only when idle)
//   abort_in        : return to idle, overriding every other transition
//   continuous_in   : wrap back to ANGLE_MIN after ANGLE_MAX
//   echo_done_in    : receive path finished (honoured only while waiting)
//   angle_out       : current signed steering angle
//   delay_valid_out : element_idx_out/delay_out are valid
//   element_idx_out : element the delay applies to
//   delay_out       : transmit delay in clock cycles, saturating
//   fire_out        : one-cycle burst trigger
//   sweep_done_out  : one-cycle pulse after the last angle completes
//   busy_out        : sequencer is not idle
// All outputs are registered and change together with the state register.
// NUM_ELEMENTS must be at least 2.
module beam_sweep_scheduler
  import sonic_sight_pkg::*;
#(
  parameter int ANGLE_MIN    = -30,
  parameter int ANGLE_MAX    = 30,
  parameter int ANGLE_STEP   = 2,
  parameter int NUM_ELEMENTS = 4,
  parameter int DELAY_SCALE  = 2915,
  parameter int DELAY_WIDTH  = 16,
  parameter int ECHO_TIMEOUT = 2_000_000
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic                            abort_in,
  input  logic                            continuous_in,
  input  logic                            echo_done_in,
  output logic signed [ANGLE_WIDTH-1:0]   angle_out,
  output logic                            delay_valid_out,
  output logic [$clog2(NUM_ELEMENTS)-1:0] element_idx_out,
  output logic [DELAY_WIDTH-1:0]          delay_out,
  output logic                            fire_out,
  output logic                            sweep_done_out,
  output logic                            busy_out
);

  localparam int IDX_W = $clog2(NUM_ELEMENTS);
  localparam int TMO_W = (ECHO_TIMEOUT > 1) ? $clog2(ECHO_TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]              IDX_LAST  = IDX_W'(NUM_ELEMENTS - 1);
  localparam logic [TMO_W-1:0]              TMO_LAST  = TMO_W'(ECHO_TIMEOUT - 1);
  localparam logic signed [ANGLE_WIDTH-1:0] MIN_ANGLE = ANGLE_WIDTH'(ANGLE_MIN);
  // One bit wider than the angle so angle + step never wraps before the
  // end-of-sweep comparison.
  localparam logic signed [ANGLE_WIDTH:0]   MAX_WIDE  = (ANGLE_WIDTH + 1)'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH:0]   STEP_WIDE = (ANGLE_WIDTH + 1)'(ANGLE_STEP);
  localparam logic [DELAY_WIDTH-1:0]        DELAY_SAT = '1;

  sweep_state_t state, state_next;

  logic signed [ANGLE_WIDTH-1:0] angle_next;
  logic signed [ANGLE_WIDTH:0]   angle_sum;
  logic [SIN_WIDTH-1:0]          base_q, base_next;
  logic                          sign_q, sign_next;
  logic [TMO_W-1:0]              tmo_q, tmo_next;
  logic                          valid_next, fire_next, done_next;
  logic [IDX_W-1:0]              idx_next;
  logic [DELAY_WIDTH-1:0]        delay_next;

  // LUT and base scaling: base = (DELAY_SCALE * mag) >> 16.
  logic [SIN_WIDTH-1:0]   lut_mag;
  logic                   lut_neg;
  logic [2*SIN_WIDTH-2:0] lut_prod;
  logic [SIN_WIDTH-1:0]   lut_base;

  sin_lut u_sin_lut (
    .angle (angle_out),
    .mag   (lut_mag),
    .neg   (lut_neg)
  );

  assign lut_prod  = (2*SIN_WIDTH-1)'(DELAY_SCALE) * (2*SIN_WIDTH-1)'(lut_mag);
  assign lut_base  = lut_prod[2*SIN_WIDTH-2:16];
  assign angle_sum = $signed({angle_out[ANGLE_WIDTH-1], angle_out}) + STEP_WIDE;

  // Next-state and next-output logic.
  always_comb begin
    state_next = state;
    angle_next = angle_out;
    base_next  = base_q;
    sign_next  = sign_q;
    tmo_next   = tmo_q;
    valid_next = 1'b0;
    idx_next   = '0;
    fire_next  = 1'b0;
    done_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_in) begin
          angle_next = MIN_ANGLE;
          state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        base_next  = lut_base;
        sign_next  = lut_neg;
        valid_next = 1'b1;
        state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (element_idx_out == IDX_LAST) begin
          fire_next  = 1'b1;
          state_next = ST_FIRE;
        end else begin
          idx_next   = element_idx_out + 1'b1;
          valid_next = 1'b1;
        end
      end
      ST_FIRE: begin
        tmo_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (echo_done_in || tmo_q == TMO_LAST) begin
          state_next = ST_ADVANCE;
        end else begin
          tmo_next = tmo_q + 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (angle_sum > MAX_WIDE) begin
          done_next = 1'b1;
          if (continuous_in) begin
            angle_next = MIN_ANGLE;
            state_next = ST_LOOKUP;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          angle_next = angle_sum[ANGLE_WIDTH-1:0];
          state_next = ST_LOOKUP;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort wins over everything, including a simultaneous start.
    if (abort_in) begin
      state_next = ST_IDLE;
      angle_next = angle_out;
      valid_next = 1'b0;
      idx_next   = '0;
      fire_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

  // Delay for the element about to be presented. On the LOOKUP->EMIT edge
  // the base and sign are taken straight from the LUT path because the
  // registers are only being loaded on that same edge.
  logic [SIN_WIDTH-1:0] base_sel;
  logic                 sign_sel;
  logic [IDX_W-1:0]     mult_sel;
  logic [63:0]          delay_full;

  always_comb begin
    base_sel   = (state == ST_LOOKUP) ? lut_base : base_q;
    sign_sel   = (state == ST_LOOKUP) ? lut_neg  : sign_q;
    mult_sel   = sign_sel ? (IDX_LAST - idx_next) : idx_next;
    delay_full = 64'(base_sel) * 64'(mult_sel);
    delay_next = '0;
    if (valid_next) begin
      delay_next = (delay_full > 64'(DELAY_SAT)) ? DELAY_SAT : delay_full[DELAY_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_in) begin
      state           <= ST_IDLE;
      angle_out       <= '0;
      base_q          <= '0;
      sign_q          <= 1'b0;
      tmo_q           <= '0;
      delay_valid_out <= 1'b0;
      element_idx_out <= '0;
      delay_out       <= '0;
      fire_out        <= 1'b0;
      sweep_done_out  <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      state           <= state_next;
      angle_out       <= angle_next;
      base_q          <= base_next;
      sign_q          <= sign_next;
      tmo_q           <= tmo_next;
      delay_valid_out <= valid_next;
      element_idx_out <= idx_next;
      delay_out       <= delay_next;
      fire_out        <= fire_next;
      sweep_done_out  <= done_next;
      busy_out        <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Self-checking bench for beam_sweep_scheduler. Five instances with different
// parameter sets share the control inputs; each test resets all of them and
// inspects only the instance it targets.
//   inst 0: MIN=MAX=0            inst 1: MIN=MAX=30       inst 2: MIN=MAX=-30
//   inst 3: -4..4 step 4, ECHO_TIMEOUT=10                 inst 4: MIN=MAX=60, DELAY_WIDTH=12
module tb_beam_sweep_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, cont, echo;

  logic signed [7:0] angle_a [5];
  logic              valid_a [5];
  logic [1:0]        idx_a   [5];
  logic [15:0]       delay_a [5];
  logic              fire_a  [5];
  logic              done_a  [5];
  logic              busy_a  [5];
  logic [11:0]       delay_e;

  assign delay_a[4] = {4'b0000, delay_e};

  beam_sweep_scheduler #(.ANGLE_MIN(0), .ANGLE_MAX(0)) u0 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort), .continuous_in(cont),
    .echo_done_in(echo), .angle_out(angle_a[0]), .delay_valid_out(valid_a[0]),
    .element_idx_out(idx_a[0]), .delay_out(delay_a[0]), .fire_out(fire_a[0]),
    .sweep_done_out(done_a[0]), .busy_out(busy_a[0]));

  beam_sweep_scheduler #(.ANGLE_MIN(30), .ANGLE_MAX(30)) u1 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort), .continuous_in(cont),
    .echo_done_in(echo), .angle_out(angle_a[1]), .delay_valid_out(valid_a[1]),
    .element_idx_out(idx_a[1]), .delay_out(delay_a[1]), .fire_out(fire_a[1]),
    .sweep_done_out(done_a[1]), .busy_out(busy_a[1]));

  beam_sweep_scheduler #(.ANGLE_MIN(-30), .ANGLE_MAX(-30)) u2 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort), .continuous_in(cont),
    .echo_done_in(echo), .angle_out(angle_a[2]), .delay_valid_out(valid_a[2]),
    .element_idx_out(idx_a[2]), .delay_out(delay_a[2]), .fire_out(fire_a[2]),
    .sweep_done_out(done_a[2]), .busy_out(busy_a[2]));

  beam_sweep_scheduler #(.ANGLE_MIN(-4), .ANGLE_MAX(4), .ANGLE_STEP(4), .ECHO_TIMEOUT(10)) u3 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort), .continuous_in(cont),
    .echo_done_in(echo), .angle_out(angle_a[3]), .delay_valid_out(valid_a[3]),
    .element_idx_out(idx_a[3]), .delay_out(delay_a[3]), .fire_out(fire_a[3]),
    .sweep_done_out(done_a[3]), .busy_out(busy_a[3]));

  beam_sweep_scheduler #(.ANGLE_MIN(60), .ANGLE_MAX(60), .DELAY_WIDTH(12)) u4 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort), .continuous_in(cont),
    .echo_done_in(echo), .angle_out(angle_a[4]), .delay_valid_out(valid_a[4]),
    .element_idx_out(idx_a[4]), .delay_out(delay_e), .fire_out(fire_a[4]),
    .sweep_done_out(done_a[4]), .busy_out(busy_a[4]));

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int                dut;
    logic signed [7:0] angle;
    logic [3:0][15:0]  d;
    logic              done;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    echo  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_vec(input int i, input int dut, input int ang,
                         input int d0, input int d1, input int d2, input int d3, input bit dn);
    vecs[i].dut   = dut;
    vecs[i].angle = 8'(ang);
    vecs[i].d[0]  = 16'(d0);
    vecs[i].d[1]  = 16'(d1);
    vecs[i].d[2]  = 16'(d2);
    vecs[i].d[3]  = 16'(d3);
    vecs[i].done  = dn;
  endtask

  // One full angle: start, LOOKUP, four delays, fire, echo, advance.
  task automatic run_emit(input int i);
    int d;
    d = vecs[i].dut;
    do_reset();
    cont  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("v%0d_lookup_busy", i), busy_a[d], 1);
    check($sformatf("v%0d_lookup_valid", i), valid_a[d], 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("v%0d_valid%0d", i, k), valid_a[d], 1);
      check($sformatf("v%0d_idx%0d", i, k), idx_a[d], k);
      check($sformatf("v%0d_delay%0d", i, k), delay_a[d], vecs[i].d[k]);
      if (k == 0) check($sformatf("v%0d_angle", i), angle_a[d], vecs[i].angle);
    end
    tick();
    check($sformatf("v%0d_fire", i), fire_a[d], 1);
    check($sformatf("v%0d_fire_valid", i), valid_a[d], 0);
    tick();
    check($sformatf("v%0d_fire_once", i), fire_a[d], 0);
    echo = 1'b1;
    tick();
    echo = 1'b0;
    tick();
    check($sformatf("v%0d_done", i), done_a[d], vecs[i].done);
    check($sformatf("v%0d_busy_after", i), busy_a[d], vecs[i].done ? 0 : 1);
  endtask

  // Inst 3 with echo_done held low: three angles, each WAIT 10 cycles.
  task automatic seq_timeout();
    int cyc, nf, nd, done_cyc;
    int fcyc [3];
    int fang [3];
    bit idle_seen;
    do_reset();
    cont  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; nf = 0; nd = 0; done_cyc = -1; idle_seen = 1'b0;
    for (int j = 0; j < 3; j++) begin fcyc[j] = -1; fang[j] = 99; end
    while (cyc < 150) begin
      if (fire_a[3]) begin
        if (nf < 3) begin fcyc[nf] = cyc; fang[nf] = angle_a[3]; end
        nf++;
      end
      if (done_a[3]) begin nd++; done_cyc = cyc; end
      if (!busy_a[3]) begin idle_seen = 1'b1; break; end
      tick();
      cyc++;
    end
    check("to_idle_reached", idle_seen, 1);
    check("to_fire_count", nf, 3);
    check("to_fire0_cycle", fcyc[0], 5);
    check("to_fire1_cycle", fcyc[1], 22);
    check("to_fire2_cycle", fcyc[2], 39);
    check("to_angle0", fang[0], -4);
    check("to_angle1", fang[1], 0);
    check("to_angle2", fang[2], 4);
    check("to_done_count", nd, 1);
    check("to_done_cycle", done_cyc, 51);
  endtask

  // Inst 3 continuous: wraps after 4, stays busy; then abort during EMIT.
  task automatic seq_continuous_abort();
    int cyc, nf, nd, nlow;
    int fang [4];
    bit seen;
    do_reset();
    cont  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; nf = 0; nd = 0; nlow = 0;
    for (int j = 0; j < 4; j++) fang[j] = 99;
    while (cyc < 200) begin
      if (fire_a[3]) begin fang[nf] = angle_a[3]; nf++; end
      if (done_a[3]) nd++;
      if (!busy_a[3]) nlow++;
      if (nf == 4) break;
      tick();
      cyc++;
    end
    check("cont_fire_count", nf, 4);
    check("cont_angle0", fang[0], -4);
    check("cont_angle1", fang[1], 0);
    check("cont_angle2", fang[2], 4);
    check("cont_angle3_wrap", fang[3], -4);
    check("cont_done_count", nd, 1);
    check("cont_busy_low_cycles", nlow, 0);
    seen = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (valid_a[3]) begin seen = 1'b1; break; end
    end
    check("cont_emit_seen", seen, 1);
    check("cont_emit_angle", angle_a[3], 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy_a[3], 0);
    check("abort_valid", valid_a[3], 0);
    check("abort_fire", fire_a[3], 0);
    check("abort_angle_hold", angle_a[3], 0);
    tick();
    check("abort_stays_idle", busy_a[3], 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy_a[3], 0);
    check("abort_start_angle", angle_a[3], 0);
    tick();
    check("abort_start_idle", busy_a[3], 0);
    cont = 1'b0;
  endtask

  // Inst 4: reset asserted while waiting for the echo clears every output.
  task automatic seq_reset_in_wait();
    bit seen;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (fire_a[4]) begin seen = 1'b1; break; end
      tick();
    end
    check("rw_fire_seen", seen, 1);
    check("rw_angle", angle_a[4], 60);
    tick();
    tick();
    tick();
    check("rw_busy_before", busy_a[4], 1);
    rst = 1'b1;
    tick();
    check("rw_angle_clr", angle_a[4], 0);
    check("rw_busy_clr", busy_a[4], 0);
    check("rw_valid_clr", valid_a[4], 0);
    check("rw_idx_clr", idx_a[4], 0);
    check("rw_delay_clr", delay_a[4], 0);
    check("rw_fire_clr", fire_a[4], 0);
    check("rw_done_clr", done_a[4], 0);
    rst = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0; echo = 1'b0;

    // base(30) = 2915*32768>>16 = 1457; base(60) = 2524; base(4) = 203.
    set_vec(0, 0,   0,    0,    0,    0,    0, 1'b1);
    set_vec(1, 1,  30,    0, 1457, 2914, 4371, 1'b1);
    set_vec(2, 2, -30, 4371, 2914, 1457,    0, 1'b1);
    set_vec(3, 4,  60,    0, 2524, 4095, 4095, 1'b1);
    set_vec(4, 3,  -4,  609,  406,  203,    0, 1'b0);

    tick();
    tick();
    for (int d = 0; d < 5; d++) begin
      check($sformatf("rst%0d_angle", d), angle_a[d], 0);
      check($sformatf("rst%0d_busy", d), busy_a[d], 0);
      check($sformatf("rst%0d_valid", d), valid_a[d], 0);
      check($sformatf("rst%0d_delay", d), delay_a[d], 0);
      check($sformatf("rst%0d_pulses", d), {fire_a[d], done_a[d]}, 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_emit(i);
    seq_timeout();
    seq_continuous_abort();
    seq_reset_in_wait();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/beam_sweep_scheduler.md
# beam_sweep_scheduler

Sequences the transmit beam steering for the ultrasonic array: it steps the steering angle across a configured range and looks up sin(θ) through the shared sine-magnitude LUT. For each angle it emits one per-element transmit delay, fires a burst, and waits for the receive path to finish before advancing. It sits between the top-level control (start/abort) and the per-transducer pulse generators, and it is the only client of its sine LUT instance.

## Interface
- `ANGLE_MIN`, default -30: first steering angle, in signed degrees; range -89..89.
- `ANGLE_MAX`, default 30: last steering angle; must be ≥ `ANGLE_MIN`.
- `ANGLE_STEP`, default 2: angle increment in degrees; must be ≥ 1.
- `NUM_ELEMENTS`, default 4: number of transducers.
- `DELAY_SCALE`, default 2915: clock cycles of inter-element delay when sin = 1 (element pitch / c × f_clk).
- `DELAY_WIDTH`, default 16: width of the delay output.
- `ECHO_TIMEOUT`, default 2_000_000: maximum number of cycles spent waiting for echo completion.
- `clk_in` input, 1 bit: the single clock.
- `rst_in` input, 1 bit: synchronous, active-high reset.
- `start_in` input, 1 bit: one-cycle pulse that begins a sweep; honoured only in IDLE.
- `abort_in` input, 1 bit: forces a return to IDLE.
- `continuous_in` input, 1 bit: when high, the sweep restarts at `ANGLE_MIN` after `ANGLE_MAX`.
- `echo_done_in` input, 1 bit: pulse from the receive path; honoured only in WAIT.
- `angle_out` output, 8 bits, signed: current steering angle.
- `delay_valid_out` output, 1 bit: high while `element_idx_out`/`delay_out` are valid.
- `element_idx_out` output, $clog2(NUM_ELEMENTS) bits: element the delay applies to.
- `delay_out` output, `DELAY_WIDTH` bits: transmit delay in cycles.
- `fire_out` output, 1 bit: one-cycle burst trigger.
- `sweep_done_out` output, 1 bit: one-cycle pulse after the last angle completes.
- `busy_out` output, 1 bit: high whenever the state is not IDLE.

## Operation
- States are IDLE, LOOKUP, EMIT, FIRE, WAIT and ADVANCE.
- IDLE: on `start_in`, `angle_out` ← `ANGLE_MIN` and the state moves to LOOKUP.
- LOOKUP (1 cycle): the LUT is driven with `angle_out` and returns a 17-bit magnitude `mag` (65536 = 1.0) plus a sign bit (1 = negative angle).
  - Register `base` = (`DELAY_SCALE` × `mag`) >> 16, truncated. The product is 33 bits wide; `base` is ≤ `DELAY_SCALE`.
  - Register the sign.
  - Go to EMIT.
- EMIT (`NUM_ELEMENTS` cycles): for k = 0..N-1, assert `delay_valid_out` with `element_idx_out` = k and `delay_out` = m × `base`.
  - m = k when the sign is positive, m = N-1-k when the sign is negative, so every delay is ≥ 0.
  - A delay that exceeds `DELAY_WIDTH` saturates to all-ones.
  - Go to FIRE.
- FIRE (1 cycle): `fire_out` = 1, the timeout counter is cleared, and the state moves to WAIT.
- WAIT: leave on `echo_done_in` or when the counter reaches `ECHO_TIMEOUT`-1, whichever comes first; go to ADVANCE.
- ADVANCE (1 cycle):
  - If `angle_out` + `ANGLE_STEP` > `ANGLE_MAX`: pulse `sweep_done_out`; then if `continuous_in` is high, `angle_out` ← `ANGLE_MIN` and go to LOOKUP, otherwise go to IDLE.
  - Otherwise `angle_out` += `ANGLE_STEP` and go to LOOKUP. The comparison is done at 9-bit signed width, so there is no wrap-around.
- `abort_in` takes priority over every transition. On the next edge the state is IDLE and all pulse outputs are 0; `angle_out` holds its value. If `abort_in` and `start_in` arrive in the same IDLE cycle, the block stays in IDLE.
- `start_in` outside IDLE and `echo_done_in` outside WAIT are ignored.

## Timing
- Reset values: state IDLE; `angle_out`, `delay_out`, `element_idx_out`, and all valid/pulse outputs are 0; `busy_out` is 0.
- `start_in` sampled high at edge t gives:
  - LOOKUP during cycle t+1;
  - first `delay_valid_out` at t+2;
  - last delay at t+1+N;
  - `fire_out` at t+2+N.
- `echo_done_in` sampled at edge e gives ADVANCE at e+1 and the next angle's first delay at e+3.
- A timeout lasts exactly `ECHO_TIMEOUT` cycles of WAIT.
- All outputs are registered. The LUT path is combinational into the `base` register, and the multiplies are single-cycle.
- `rst_in` asserted mid-sweep returns every output to its reset value on the next edge.

## Structure
- The package `sonic_sight_pkg` holds:
  - the state enum `sweep_state_t`;
  - `ANGLE_WIDTH` = 8 and `SIN_WIDTH` = 17;
  - `SIN_ONE` = 65536.
- The block instantiates one `sin_lut` sub-module, which is combinational: signed angle in, 17-bit magnitude and sign bit out. No other sub-modules are needed.

## Test plan
- Angle 0, with MIN = MAX = 0 and default scale: after `start_in`, the four delays are 0, 0, 0, 0; `fire_out` pulses once; after `echo_done_in`, `sweep_done_out` pulses and the block returns to IDLE.
- MIN = MAX = 30: delays are 0, 1457, 2914, 4371, with the first valid at t+2 and `fire_out` at t+6.
- MIN = MAX = -30: delays are 4371, 2914, 1457, 0 for elements 0..3.
- MIN = -4, MAX = 4, STEP = 4, `echo_done_in` held low, `ECHO_TIMEOUT` = 10:
  - angles run -4, 0, 4;
  - each WAIT lasts exactly 10 cycles;
  - `sweep_done_out` pulses once.
- `continuous_in` = 1 with the same range: after 4, the angle returns to -4 and `busy_out` stays high. Asserting `abort_in` during EMIT leaves the block in IDLE on the next edge with `delay_valid_out` = 0.
- DELAY_WIDTH = 12, MIN = MAX = 60: element 3 computes 3 × 2524 = 7572 and saturates to 4095. In a separate run, asserting `rst_in` during WAIT clears all outputs.
